// File: rtl/seq_stepper.sv
// Programmable sequence stepper: walks a position pointer through a run-time
// writable table in WRAP, SAT or BOUNCE mode and presents table[position].
module seq_stepper #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             step,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    last_idx,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] value,
    output logic [AW-1:0]    position,
    output logic             wrap,
    output logic             at_end
);

    localparam logic [AW-1:0] MAXIDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [1:0]    M_SAT    = 2'b01;
    localparam logic [1:0]    M_BOUNCE = 2'b10;

    logic [WIDTH-1:0] tbl [DEPTH];
    logic [AW-1:0]    last;
    logic [AW-1:0]    pos_n;
    logic             dir_q, dir_n, wrap_n;

    assign last   = (int'(last_idx) > DEPTH - 1) ? MAXIDX : last_idx;
    assign value  = tbl[position];
    assign at_end = (position == '0) || (position == last);

    // Boundary tests come before any +1/-1 so the AW-bit arithmetic never wraps.
    always_comb begin
        pos_n  = position;
        dir_n  = dir_q;
        wrap_n = 1'b0;
        if (clear) begin
            pos_n = '0;
            dir_n = 1'b1;
        end else if (step) begin
            if (position > last) begin
                pos_n  = '0;
                dir_n  = 1'b1;
                wrap_n = 1'b1;
            end else begin
                case (mode)
                    M_SAT: begin
                        if (up) begin
                            if (position != last) pos_n = position + ONE;
                        end else begin
                            if (position != '0) pos_n = position - ONE;
                        end
                    end
                    M_BOUNCE: begin
                        // A single-entry sequence has nowhere to bounce to.
                        if (last != '0) begin
                            if (dir_q) begin
                                if (position == last) begin
                                    pos_n  = last - ONE;
                                    dir_n  = 1'b0;
                                    wrap_n = 1'b1;
                                end else begin
                                    pos_n = position + ONE;
                                end
                            end else begin
                                if (position == '0) begin
                                    pos_n  = ONE;
                                    dir_n  = 1'b1;
                                    wrap_n = 1'b1;
                                end else begin
                                    pos_n = position - ONE;
                                end
                            end
                        end
                    end
                    default: begin
                        if (up) begin
                            if (position == last) begin
                                pos_n  = '0;
                                wrap_n = 1'b1;
                            end else begin
                                pos_n = position + ONE;
                            end
                        end else begin
                            if (position == '0) begin
                                pos_n  = last;
                                wrap_n = 1'b1;
                            end else begin
                                pos_n = position - ONE;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            position <= '0;
            dir_q    <= 1'b1;
            wrap     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) tbl[i] <= WIDTH'(i);
        end else begin
            position <= pos_n;
            dir_q    <= dir_n;
            wrap     <= wrap_n;
            if (wr_en && (int'(wr_addr) < DEPTH)) tbl[wr_addr] <= wr_data;
        end
    end

endmodule

// File: doc/seq_stepper.md
Name: seq_stepper

Overview:
- Parametrised, programmable sequence stepper: walks a position pointer through a writable lookup table and outputs the table entry at the current position.
- Generalises a fixed 8-entry, 4-bit, up/down wrap-around sequence generator in four ways: table width and depth are parameters, the table is run-time writable, the active length is programmable, and three stepping modes (wrap, saturate, bounce) are supported.
- Used wherever the design needs a stepped pattern, such as display or LED sequences and test stimulus.

Parameters:
- WIDTH, 4, bit width of each table entry and of value.
- DEPTH, 8, number of table entries; must be at least 2.
- AW, $clog2(DEPTH), address and position width (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous restart: position to 0, bounce direction to up.
- step  in  1  advance one position this cycle.
- up  in  1  direction for WRAP/SAT modes; 1 = increment, 0 = decrement.
- mode  in  2  00 WRAP, 01 SAT, 10 BOUNCE, 11 treated as WRAP.
- last_idx  in  AW  index of the last active entry; values above DEPTH-1 are clamped to DEPTH-1.
- wr_en  in  1  table write strobe.
- wr_addr  in  AW  table write address; writes with wr_addr > DEPTH-1 are ignored.
- wr_data  in  WIDTH  table write data.
- value  out  WIDTH  table[position], combinational read of registered state.
- position  out  AW  current position register.
- wrap  out  1  registered one-cycle pulse on a sequence boundary event.
- at_end  out  1  combinational: 1 when position==0 or position==last (last = clamped last_idx).

Behaviour:
- Reset (async, rst=1): position=0, dir_q=up, wrap=0, table[i]=i truncated to WIDTH for all i. With defaults, value=0 immediately while rst is asserted.
- Priority per edge: rst > clear > step. Table writes are independent of stepping and occur in the same edge as any step.
- clear=1: position<=0, dir_q<=up, wrap<=0; step is ignored that cycle.
- step=0: position and dir_q hold; wrap<=0.
- Out-of-range position: if step=1 and position > last (possible after last_idx was lowered), position<=0, dir_q<=up, wrap<=1, in every mode.
- WRAP mode:
  - up=1: position<=position+1; at last, position<=0 and wrap<=1.
  - up=0: position<=position-1; at 0, position<=last and wrap<=1.
- SAT mode:
  - Same increment/decrement as WRAP, but at last (up=1) or at 0 (up=0) position holds.
  - wrap<=0 always in SAT mode.
- BOUNCE mode:
  - The up input is ignored; dir_q sets the direction.
  - dir_q=up: position+1; at last, position<=last-1, dir_q<=down, wrap<=1.
  - dir_q=down: position-1; at 0, position<=1, dir_q<=up, wrap<=1.
  - If last==0: position stays 0, dir_q unchanged, wrap<=0.
- Mode change mid-sequence: takes effect on the next step from the current position. dir_q is retained and only used in BOUNCE.
- Latency:
  - A step at edge k is visible on position/value after edge k.
  - A write at edge k is visible after edge k; if wr_addr==new position, value shows wr_data after edge k.
- Arithmetic is unsigned AW-bit with no overflow: boundary checks precede the +1/-1.
- wrap asserts for exactly one cycle per boundary event. Consecutive boundary events (e.g. last==0 in WRAP) give a wrap that stays high on each stepping cycle.

Test Plan:
- Reset then WRAP, up=1, step=1 for 10 cycles, last_idx=7 -> value 0,1,...,7,0,1; wrap high exactly on the 7->0 cycle; then up=0 from position 1 -> 0,7 with wrap on the 0->7 cycle.
- SAT, up=1, last_idx=3, 6 steps -> position 1,2,3,3,3,3; wrap never asserted; at_end=1 from position 3 onward.
- BOUNCE, last_idx=3, 8 steps from 0 -> position 1,2,3,2,1,0,1,2; wrap pulses on the 3->2 and 0->1 transitions.
- Write table[2]=0xA while stepping from 1 to 2 in the same cycle -> value=0xA after that edge; write to wr_addr > DEPTH-1 leaves the table unchanged.
- At position 6, lower last_idx to 3 and step -> position 0, wrap=1; clear and step asserted together -> position 0, no wrap.
- Assert rst asynchronously mid-BOUNCE with dir_q=down -> position=0 and value=0 before the next clock edge; the next step goes to 1 (dir_q reset to up).
